vst_access_ctrl: RTL and testbench
==================================

Name: vst_access_ctrl

Overview:
- Sequences all accesses to the variable state table (VST), a 3-row × VAR_NUM-bit store inside the BCP unit.
- Arbitrates among three requesters:
  - decision unit: clears one free bit.
  - BCP write-back: writes a full row.
  - reader: reads a row.
- Drives the VST command port (vst_en, vst_write, vst_bcp_write, vst_address, vst_in, rewrite_free_bit).
- Captures and holds read data. The VST zeroes its output whenever vst_en is low, so the capture is required.

Parameters:
- VAR_NUM, 8, row width / number of variables.
- VAR_NUM_LOG, 3, bit-index width (log2 VAR_NUM).
- ROW_NUM, 3, legal rows 0..ROW_NUM-1.
- RD_MAX_WAIT, 4, cycles a pending read may lose arbitration before it is forced to win.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- dec_req  in  1  decision-unit free-bit clear request.
- dec_addr  in  2  row to modify.
- dec_bit  in  VAR_NUM_LOG  bit index to clear.
- dec_gnt  out  1  one-cycle acceptance pulse.
- bcp_req  in  1  BCP full-row write request.
- bcp_addr  in  2  row to write.
- bcp_data  in  VAR_NUM  row data.
- bcp_gnt  out  1  one-cycle acceptance pulse.
- rd_req  in  1  row read request.
- rd_addr  in  2  row to read.
- rd_gnt  out  1  one-cycle acceptance pulse.
- rd_valid  out  1  one-cycle read-data-valid pulse.
- rd_data  out  VAR_NUM  captured row; held until the next capture.
- vst_en, vst_write, vst_bcp_write  out  1 each  VST command strobes.
- vst_address  out  3  VST row select.
- vst_in  out  VAR_NUM  VST write data.
- rewrite_free_bit  out  VAR_NUM_LOG  VST bit select.
- vst_out  in  VAR_NUM  VST registered read data.
- addr_err  out  1  sticky; set on any request with address ≥ ROW_NUM.

Behaviour:
- Reset (rst=0 at clk edge):
  - All outputs are 0, rd_data is 0, FSM goes to IDLE, the wait counter is 0.
  - A read in flight is dropped: no rd_valid is issued.
  - The reset has priority over every other event.
- Requester protocol:
  - A requester holds req and its address/data stable until it sees its gnt high.
  - It may deassert req in the cycle after gnt, or keep req high to issue a new request.
- Arbitration:
  - Performed at a clk edge when the FSM is in IDLE or in CMD_WR.
  - Default priority: bcp > dec > rd.
  - The read wins instead when wait_cnt == RD_MAX_WAIT.
- Wait counter (wait_cnt):
  - Increments each arbitration edge where rd_req=1 and the read loses.
  - Saturates at RD_MAX_WAIT.
  - Clears when the read is granted.
- Outputs registered at the winning edge; during the next cycle:
  - The winner's gnt = 1.
  - VST strobes are driven for exactly that one cycle.
  - All other strobes are 0.
- Commands driven per winner:
  - dec: vst_en=1, vst_write=1, vst_address=dec_addr, rewrite_free_bit=dec_bit.
  - bcp: vst_en=1, vst_bcp_write=1, vst_address=bcp_addr, vst_in=bcp_data.
  - rd: vst_en=1, both write strobes 0, vst_address=rd_addr.
- States and transitions:
  - IDLE:
    - Any req → CMD_WR (dec/bcp win) or CMD_RD (rd wins).
    - No req → stay in IDLE.
  - CMD_WR:
    - Arbitrates again, so back-to-back writes issue one per cycle.
    - No req → IDLE.
  - CMD_RD:
    - The VST latches vst_out at this cycle's end edge.
    - Always → RD_CAP.
    - No arbitration happens in this state, and vst_en=0.
  - RD_CAP:
    - At the end edge: rd_data ← vst_out, rd_valid=1 in the next cycle, state → IDLE.
    - No arbitration happens in this state.
- Read latency:
  - Read req sampled at edge N.
  - rd_gnt high during cycle N+1.
  - rd_valid and rd_data valid during cycle N+3.
  - The next arbitration happens at edge N+3 earliest.
- Illegal address (≥ ROW_NUM):
  - The request is granted normally and addr_err is set (sticky, reset only).
  - No VST strobe is driven; vst_en stays 0.
  - An illegal read still yields rd_valid at N+3, with rd_data=0.
- Simultaneous dec and bcp to the same row:
  - bcp is applied first; dec is applied in the following cycle.
  - The final row is bcp_data with dec_bit cleared.
- vst_en is 0 in every cycle without a command.

Test Plan:
- Reset, then rd_req with rd_addr=0 → rd_gnt one cycle later; rd_valid 3 cycles after the request edge; rd_data=8'hFF.
- bcp_req with addr=2, data=8'hA5, then rd row 2 → rd_data=8'hA5; vst_bcp_write pulses for exactly 1 cycle.
- dec_req and bcp_req asserted together, both addr=1, bcp_data=8'hF0, dec_bit=5, then read row 1 → bcp_gnt precedes dec_gnt by 1 cycle; rd_data=8'hD0.
- rd_req held while bcp_req is continuously asserted → rd_gnt after exactly 4 lost arbitrations; wait_cnt returns to 0.
- rd_req with addr=3 → rd_gnt, no vst_en, addr_err=1 and it stays 1; rd_valid with rd_data=0.
- rst=0 during CMD_RD → no rd_valid; all outputs 0 next cycle; FSM restarts in IDLE.

Source files
------------

// File: rtl/vst_access_ctrl.sv
// rtl/vst_access_ctrl.sv - VST command sequencer arbitrating decision, BCP write-back and read requesters
module vst_access_ctrl #(
  parameter int VAR_NUM     = 8,
  parameter int VAR_NUM_LOG = 3,
  parameter int ROW_NUM     = 3,
  parameter int RD_MAX_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dec_req,
  input  logic [1:0]             dec_addr,
  input  logic [VAR_NUM_LOG-1:0] dec_bit,
  output logic                   dec_gnt,
  input  logic                   bcp_req,
  input  logic [1:0]             bcp_addr,
  input  logic [VAR_NUM-1:0]     bcp_data,
  output logic                   bcp_gnt,
  input  logic                   rd_req,
  input  logic [1:0]             rd_addr,
  output logic                   rd_gnt,
  output logic                   rd_valid,
  output logic [VAR_NUM-1:0]     rd_data,
  output logic                   vst_en,
  output logic                   vst_write,
  output logic                   vst_bcp_write,
  output logic [2:0]             vst_address,
  output logic [VAR_NUM-1:0]     vst_in,
  output logic [VAR_NUM_LOG-1:0] rewrite_free_bit,
  input  logic [VAR_NUM-1:0]     vst_out,
  output logic                   addr_err
);

  localparam int WAIT_W = $clog2(RD_MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, CMD_WR, CMD_RD, RD_CAP} state_t;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              rd_bad;

  logic arb_ok;
  logic rd_force;
  logic win_bcp;
  logic win_dec;
  logic win_rd;

  function automatic logic legal(input logic [1:0] a);
    return int'(a) < ROW_NUM;
  endfunction

  // A starved read overrides the fixed bcp > dec > rd order.
  assign arb_ok   = (state == IDLE) || (state == CMD_WR);
  assign rd_force = rd_req && (wait_cnt == WAIT_W'(RD_MAX_WAIT));
  assign win_bcp  = arb_ok && bcp_req && !rd_force;
  assign win_dec  = arb_ok && dec_req && !bcp_req && !rd_force;
  assign win_rd   = arb_ok && rd_req && (rd_force || (!bcp_req && !dec_req));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state            <= IDLE;
      wait_cnt         <= '0;
      rd_bad           <= 1'b0;
      dec_gnt          <= 1'b0;
      bcp_gnt          <= 1'b0;
      rd_gnt           <= 1'b0;
      rd_valid         <= 1'b0;
      rd_data          <= '0;
      vst_en           <= 1'b0;
      vst_write        <= 1'b0;
      vst_bcp_write    <= 1'b0;
      vst_address      <= '0;
      vst_in           <= '0;
      rewrite_free_bit <= '0;
      addr_err         <= 1'b0;
    end else begin
      dec_gnt          <= 1'b0;
      bcp_gnt          <= 1'b0;
      rd_gnt           <= 1'b0;
      rd_valid         <= 1'b0;
      vst_en           <= 1'b0;
      vst_write        <= 1'b0;
      vst_bcp_write    <= 1'b0;
      vst_address      <= '0;
      vst_in           <= '0;
      rewrite_free_bit <= '0;

      case (state)
        IDLE, CMD_WR: begin
          if (win_bcp) begin
            bcp_gnt <= 1'b1;
            state   <= CMD_WR;
            if (legal(bcp_addr)) begin
              vst_en        <= 1'b1;
              vst_bcp_write <= 1'b1;
              vst_address   <= {1'b0, bcp_addr};
              vst_in        <= bcp_data;
            end else begin
              addr_err <= 1'b1;
            end
          end else if (win_dec) begin
            dec_gnt <= 1'b1;
            state   <= CMD_WR;
            if (legal(dec_addr)) begin
              vst_en           <= 1'b1;
              vst_write        <= 1'b1;
              vst_address      <= {1'b0, dec_addr};
              rewrite_free_bit <= dec_bit;
            end else begin
              addr_err <= 1'b1;
            end
          end else if (win_rd) begin
            rd_gnt <= 1'b1;
            state  <= CMD_RD;
            rd_bad <= !legal(rd_addr);
            if (legal(rd_addr)) begin
              vst_en      <= 1'b1;
              vst_address <= {1'b0, rd_addr};
            end else begin
              addr_err <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end

          if (win_rd)
            wait_cnt <= '0;
          else if (rd_req && (wait_cnt != WAIT_W'(RD_MAX_WAIT)))
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
        CMD_RD: state <= RD_CAP;
        RD_CAP: begin
          // The VST only presents the row for one cycle, so it is captured here.
          rd_data  <= rd_bad ? '0 : vst_out;
          rd_valid <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vst_access_ctrl.sv
// tb/tb_vst_access_ctrl.sv - self-checking bench for vst_access_ctrl against a transaction-level model
module tb_vst_access_ctrl;
  localparam int VN  = 8;
  localparam int VL  = 3;
  localparam int RN  = 3;
  localparam int RMW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          dec_req, bcp_req, rd_req;
  logic [1:0]    dec_addr, bcp_addr, rd_addr;
  logic [VL-1:0] dec_bit;
  logic [VN-1:0] bcp_data;
  logic          dec_gnt, bcp_gnt, rd_gnt, rd_valid;
  logic [VN-1:0] rd_data;
  logic          vst_en, vst_write, vst_bcp_write;
  logic [2:0]    vst_address;
  logic [VN-1:0] vst_in;
  logic [VL-1:0] rewrite_free_bit;
  logic [VN-1:0] vst_out;
  logic          addr_err;

  always #5 clk = ~clk;

  vst_access_ctrl #(.VAR_NUM(VN), .VAR_NUM_LOG(VL), .ROW_NUM(RN), .RD_MAX_WAIT(RMW)) dut (
    .clk(clk), .rst(rst),
    .dec_req(dec_req), .dec_addr(dec_addr), .dec_bit(dec_bit), .dec_gnt(dec_gnt),
    .bcp_req(bcp_req), .bcp_addr(bcp_addr), .bcp_data(bcp_data), .bcp_gnt(bcp_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .vst_en(vst_en), .vst_write(vst_write), .vst_bcp_write(vst_bcp_write),
    .vst_address(vst_address), .vst_in(vst_in), .rewrite_free_bit(rewrite_free_bit),
    .vst_out(vst_out), .addr_err(addr_err)
  );

  // Behavioural VST: registered read port that outputs zero whenever no read is commanded.
  logic          vst_clear;
  logic [VN-1:0] vst_mem [0:7];
  always @(posedge clk) begin
    if (vst_clear) begin
      for (int i = 0; i < 8; i++) vst_mem[i] <= '1;
    end else if (vst_en && vst_bcp_write) begin
      vst_mem[vst_address] <= vst_in;
    end else if (vst_en && vst_write) begin
      vst_mem[vst_address][rewrite_free_bit] <= 1'b0;
    end
    vst_out <= (vst_en && !vst_write && !vst_bcp_write) ? vst_mem[vst_address] : '0;
  end

  logic [VN-1:0] ref_mem [0:3];
  logic [VN-1:0] rd_hold;
  logic          err_exp;
  int            lost, blk;
  int            total = 0;
  int            bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] all_out();
    return {2'b0, dec_gnt, bcp_gnt, rd_gnt, rd_valid, rd_data, vst_en, vst_write, vst_bcp_write,
            vst_address, vst_in, rewrite_free_bit, addr_err};
  endfunction

  // Presents a set of simultaneous requests and follows them to completion, predicting grant
  // order from priority and read starvation, and data from a row-level memory model.
  task automatic run_op(input logic b, input logic [1:0] ba, input logic [7:0] bd,
                        input logic d, input logic [1:0] da, input logic [2:0] db,
                        input logic r, input logic [1:0] ra);
    logic        pb, pd, pr;
    int          gk, win;
    logic [7:0]  rexp;
    logic [16:0] ecmd;
    pb = b; pd = d; pr = r; gk = -100; rexp = '0;
    bcp_req = b; bcp_addr = ba; bcp_data = bd;
    dec_req = d; dec_addr = da; dec_bit = db;
    rd_req = r;  rd_addr = ra;
    for (int k = 0; k < 30; k++) begin
      if (!pb && !pd && !pr && k > gk + 2) break;
      @(posedge clk); #1;
      win  = 0;
      ecmd = '0;
      if (blk > 0) blk--;
      else if (pb || pd || pr) begin
        if (pr && lost == RMW) win = 3;
        else if (pb) win = 1;
        else if (pd) win = 2;
        else win = 3;
        if (pr && win != 3 && lost < RMW) lost++;
        if (win == 3) begin lost = 0; blk = 2; end
      end
      case (win)
        1: begin
          pb = 0; bcp_req = 0;
          if (ba < RN) begin ecmd = {3'b101, 1'b0, ba, bd, 3'b000}; ref_mem[ba] = bd; end
          else err_exp = 1'b1;
        end
        2: begin
          pd = 0; dec_req = 0;
          if (da < RN) begin ecmd = {3'b110, 1'b0, da, 8'h00, db}; ref_mem[da][db] = 1'b0; end
          else err_exp = 1'b1;
        end
        3: begin
          pr = 0; rd_req = 0; gk = k;
          if (ra < RN) begin ecmd = {3'b100, 1'b0, ra, 8'h00, 3'b000}; rexp = ref_mem[ra]; end
          else begin err_exp = 1'b1; rexp = '0; end
        end
        default: ;
      endcase
      if (k == gk + 2) rd_hold = rexp;
      chk("gnt", {bcp_gnt, dec_gnt, rd_gnt}, {win == 1, win == 2, win == 3});
      chk("vst_cmd", {vst_en, vst_write, vst_bcp_write, vst_address, vst_in, rewrite_free_bit}, ecmd);
      chk("rd_valid", rd_valid, k == gk + 2);
      chk("rd_data", rd_data, rd_hold);
      chk("addr_err", addr_err, err_exp);
    end
    chk("op_pending", {pb, pd, pr}, 3'b000);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk("idle_out", {dec_gnt, bcp_gnt, rd_gnt, rd_valid, vst_en, vst_write, vst_bcp_write}, 7'd0);
    end
  endtask

  initial begin
    int         nb;
    logic       got;
    logic       b, d, r;
    logic [1:0] ba, da, ra;

    rst = 1'b0; vst_clear = 1'b1;
    dec_req = 0; bcp_req = 0; rd_req = 0;
    dec_addr = 0; bcp_addr = 0; rd_addr = 0; dec_bit = 0; bcp_data = 0;
    for (int i = 0; i < 4; i++) ref_mem[i] = 8'hFF;
    rd_hold = '0; err_exp = 1'b0; lost = 0; blk = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out", all_out(), 32'd0);
    vst_clear = 1'b0; rst = 1'b1;
    idle(2);

    run_op(0, 2'd0, 8'h00, 0, 2'd0, 3'd0, 1, 2'd0);
    chk("read_row0_ff", rd_data, 8'hFF);
    run_op(1, 2'd2, 8'hA5, 0, 2'd0, 3'd0, 0, 2'd0);
    idle(1);
    run_op(0, 2'd0, 8'h00, 0, 2'd0, 3'd0, 1, 2'd2);
    chk("read_row2_a5", rd_data, 8'hA5);
    run_op(1, 2'd1, 8'hF0, 1, 2'd1, 3'd5, 0, 2'd0);
    run_op(0, 2'd0, 8'h00, 0, 2'd0, 3'd0, 1, 2'd1);
    chk("read_row1_d0", rd_data, 8'hD0);

    // Read starved by a continuously asserted BCP write, twice, to show the counter clears.
    bcp_req = 1; bcp_addr = 2'd0; bcp_data = 8'h3C; ref_mem[0] = 8'h3C;
    for (int round = 0; round < 2; round++) begin
      rd_req = 1; rd_addr = 2'd0; nb = 0; got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(posedge clk); #1;
        if (bcp_gnt) nb++;
        if (rd_gnt) begin
          got = 1'b1; rd_req = 0;
          if (round == 1) bcp_req = 0;
        end
      end
      chk("starve_losses", nb, RMW);
      @(posedge clk); #1;
      chk("starve_no_valid", rd_valid, 1'b0);
      @(posedge clk); #1;
      chk("starve_valid", rd_valid, 1'b1);
      chk("starve_data", rd_data, 8'h3C);
    end
    rd_hold = 8'h3C;
    idle(1);

    run_op(0, 2'd0, 8'h00, 0, 2'd0, 3'd0, 1, 2'd3);
    chk("illegal_rd_zero", rd_data, 8'h00);
    chk("illegal_err", addr_err, 1'b1);
    run_op(1, 2'd0, 8'h5A, 0, 2'd0, 3'd0, 0, 2'd0);
    chk("err_sticky", addr_err, 1'b1);

    // Reset lands on the edge that ends CMD_RD.
    rd_req = 1; rd_addr = 2'd1;
    @(posedge clk); #1;
    chk("rst_rd_gnt", rd_gnt, 1'b1);
    rd_req = 0; rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_outputs", all_out(), 32'd0);
    rst = 1'b1;
    rd_hold = '0; err_exp = 1'b0; lost = 0; blk = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_no_valid", rd_valid, 1'b0);
    end
    run_op(0, 2'd0, 8'h00, 0, 2'd0, 3'd0, 1, 2'd1);

    for (int i = 0; i < 40; i++) begin
      b = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (!(b || d || r)) r = 1'b1;
      ba = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      da = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      run_op(b, ba, 8'($urandom), d, da, 3'($urandom_range(0, 7)), r, ra);
      idle(int'($urandom_range(0, 2)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
